// File: rtl/time_set_ctrl.sv
// Set-mode controller for a four-digit HH:MM clock: walks the selected digit on mode presses,
// increments it on up presses or auto-repeat, and returns to RUN after a period of inactivity.
module time_set_ctrl #(
   parameter int unsigned REPEAT_DLY  = 50_000_000,
   parameter int unsigned REPEAT_RATE = 10_000_000,
   parameter int unsigned IDLE_TO     = 500_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       mode_btn,
   input  logic       up_btn,
   input  logic [3:0] q_ht,
   input  logic [3:0] q_ho,
   input  logic [3:0] q_mt,
   input  logic [3:0] q_mo,
   output logic       set_ht,
   output logic       set_ho,
   output logic       set_mt,
   output logic       set_mo,
   output logic [3:0] new_val,
   output logic [1:0] sel,
   output logic       run_en
);

   localparam int unsigned RptMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int unsigned RptW   = $clog2(RptMax + 1);
   localparam int unsigned IdleW  = $clog2(IDLE_TO + 1);

   typedef enum logic [2:0] {StRun, StSetHt, StSetHo, StSetMt, StSetMo} state_e;

   state_e            state_q, state_d;
   logic              mode_prev_q, up_prev_q;
   logic [RptW-1:0]   rpt_cnt_q, rpt_cnt_d;
   logic              rpt_rep_q, rpt_rep_d;
   logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
   logic [3:0]        strb_q, strb_d;
   logic [3:0]        new_val_q, new_val_d;

   logic mode_edge, up_edge, in_set, rpt_hit, up_evt, idle_act, timeout, state_chg;
   logic [3:0] ho_lim;

   function automatic logic [3:0] inc_digit(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? 4'd0 : v + 4'd1;
   endfunction

   assign mode_edge = mode_btn & ~mode_prev_q;
   assign up_edge   = up_btn & ~up_prev_q;
   assign in_set    = (state_q != StRun);
   assign ho_lim    = (q_ht == 4'd2) ? 4'd3 : 4'd9;
   // First repeat waits REPEAT_DLY after the press, later ones REPEAT_RATE after the previous one
   assign rpt_hit   = rpt_rep_q ? (rpt_cnt_q == RptW'(REPEAT_RATE))
                                : (rpt_cnt_q == RptW'(REPEAT_DLY));
   assign up_evt    = in_set & (up_edge | (up_btn & rpt_hit));
   assign idle_act  = mode_edge | up_edge | up_btn;
   assign timeout   = in_set & ~idle_act & (idle_cnt_q == IdleW'(IDLE_TO - 1));

   always_comb begin
      state_d   = state_q;
      strb_d    = 4'b0000;
      new_val_d = new_val_q;
      if (mode_edge) begin
         case (state_q)
            StRun:   state_d = StSetHt;
            StSetHt: begin
               state_d = StSetHo;
               // Leaving hour-tens at 2 can leave an illegal hour like 27; clamp it to 20
               if (q_ht == 4'd2 && q_ho > 4'd3) begin
                  strb_d    = 4'b0100;
                  new_val_d = 4'd0;
               end
            end
            StSetHo: state_d = StSetMt;
            StSetMt: state_d = StSetMo;
            default: state_d = StRun;
         endcase
      end else if (timeout) begin
         state_d = StRun;
      end else if (up_evt) begin
         case (state_q)
            StSetHt: begin
               strb_d    = 4'b1000;
               new_val_d = inc_digit(q_ht, 4'd2);
            end
            StSetHo: begin
               strb_d    = 4'b0100;
               new_val_d = inc_digit(q_ho, ho_lim);
            end
            StSetMt: begin
               strb_d    = 4'b0010;
               new_val_d = inc_digit(q_mt, 4'd5);
            end
            StSetMo: begin
               strb_d    = 4'b0001;
               new_val_d = inc_digit(q_mo, 4'd9);
            end
            default: ;
         endcase
      end
   end

   assign state_chg = (state_d != state_q);

   always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      rpt_rep_d = rpt_rep_q;
      if (!up_btn || !in_set || state_chg) begin
         rpt_cnt_d = '0;
         rpt_rep_d = 1'b0;
      end else if (up_edge) begin
         rpt_cnt_d = RptW'(1);
         rpt_rep_d = 1'b0;
      end else if (rpt_hit) begin
         rpt_cnt_d = RptW'(1);
         rpt_rep_d = 1'b1;
      end else if (rpt_cnt_q != {RptW{1'b1}}) begin
         rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
   end

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!in_set || idle_act || state_chg) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != {IdleW{1'b1}}) begin
         idle_cnt_d = idle_cnt_q + IdleW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StRun;
         mode_prev_q <= 1'b0;
         up_prev_q   <= 1'b0;
         rpt_cnt_q   <= '0;
         rpt_rep_q   <= 1'b0;
         idle_cnt_q  <= '0;
         strb_q      <= 4'b0000;
         new_val_q   <= 4'd0;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= mode_btn;
         up_prev_q   <= up_btn;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_rep_q   <= rpt_rep_d;
         idle_cnt_q  <= idle_cnt_d;
         strb_q      <= strb_d;
         new_val_q   <= new_val_d;
      end
   end

   assign {set_ht, set_ho, set_mt, set_mo} = strb_q;
   assign new_val = new_val_q;
   assign run_en  = (state_q == StRun);

   always_comb begin
      sel = 2'd0;
      case (state_q)
         StSetHo: sel = 2'd1;
         StSetMt: sel = 2'd2;
         StSetMo: sel = 2'd3;
         default: sel = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short repeat/idle parameters.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       mode_btn, up_btn;
   logic [3:0] q_ht, q_ho, q_mt, q_mo;
   logic       set_ht, set_ho, set_mt, set_mo;
   logic [3:0] new_val;
   logic [1:0] sel;
   logic       run_en;
   logic [3:0] strb;

   int total = 0;
   int bad   = 0;

   assign strb = {set_ht, set_ho, set_mt, set_mo};

   time_set_ctrl #(
      .REPEAT_DLY  (8),
      .REPEAT_RATE (4),
      .IDLE_TO     (64)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .mode_btn (mode_btn),
      .up_btn   (up_btn),
      .q_ht     (q_ht),
      .q_ho     (q_ho),
      .q_mt     (q_mt),
      .q_mo     (q_mo),
      .set_ht   (set_ht),
      .set_ho   (set_ho),
      .set_mt   (set_mt),
      .set_mo   (set_mo),
      .new_val  (new_val),
      .sel      (sel),
      .run_en   (run_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mode_pulse();
      mode_btn = 1'b1;
      tick();
      mode_btn = 1'b0;
      tick();
   endtask

   logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic       any_strb;

   initial begin
      resetn   = 1'b0;
      mode_btn = 1'b0;
      up_btn   = 1'b0;
      q_ht = 4'd1; q_ho = 4'd5; q_mt = 4'd0; q_mo = 4'd0;
      tick();
      tick();
      check("rst_sel", sel, 2'd0);
      check("rst_run_en", run_en, 1'b1);
      check("rst_strb", strb, 4'b0000);
      check("rst_new_val", new_val, 4'd0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Up in RUN is ignored
      up_btn = 1'b1;
      tick();
      check("run_up_strb", strb, 4'b0000);
      up_btn = 1'b0;
      tick();

      // Mode walk
      for (int i = 0; i < 5; i++) begin
         mode_btn = 1'b1;
         tick();
         check("walk_sel", sel, exp_sel[i]);
         check("walk_run_en", run_en, (i == 4) ? 1'b1 : 1'b0);
         check("walk_strb", strb, 4'b0000);
         mode_btn = 1'b0;
         tick();
         check("walk_strb2", strb, 4'b0000);
      end

      // Hour-ones wrap at 23
      mode_pulse();
      mode_pulse();
      q_ht = 4'd2; q_ho = 4'd3;
      up_btn = 1'b1;
      tick();
      check("ho_wrap_strb", strb, 4'b0100);
      check("ho_wrap_val", new_val, 4'd0);
      tick();
      check("ho_wrap_one_cycle", strb, 4'b0000);
      up_btn = 1'b0;
      tick();
      q_ht = 4'd1; q_ho = 4'd5;
      up_btn = 1'b1;
      tick();
      check("ho_inc_strb", strb, 4'b0100);
      check("ho_inc_val", new_val, 4'd6);
      up_btn = 1'b0;
      tick();
      check("hold_strb", strb, 4'b0000);
      check("hold_val", new_val, 4'd6);

      // To SET_HT: HO -> MT -> MO -> RUN -> HT
      for (int i = 0; i < 4; i++) mode_pulse();
      check("ht_sel", sel, 2'd0);
      check("ht_run_en", run_en, 1'b0);
      up_btn = 1'b1;
      tick();
      check("ht_inc_strb", strb, 4'b1000);
      check("ht_inc_val", new_val, 4'd2);
      up_btn = 1'b0;
      tick();
      q_ht = 4'd2; q_ho = 4'd0;
      up_btn = 1'b1;
      tick();
      check("ht_wrap_val", new_val, 4'd0);
      up_btn = 1'b0;
      tick();

      // Clamp on leaving SET_HT at 27
      q_ht = 4'd2; q_ho = 4'd7;
      mode_btn = 1'b1;
      tick();
      check("clamp_strb", strb, 4'b0100);
      check("clamp_val", new_val, 4'd0);
      check("clamp_sel", sel, 2'd1);
      mode_btn = 1'b0;
      tick();

      // SET_MT: wrap and above-limit
      mode_pulse();
      check("mt_sel", sel, 2'd2);
      q_mt = 4'd5;
      up_btn = 1'b1;
      tick();
      check("mt_wrap_strb", strb, 4'b0010);
      check("mt_wrap_val", new_val, 4'd0);
      up_btn = 1'b0;
      tick();
      q_mt = 4'd12; q_mo = 4'd0;
      up_btn = 1'b1;
      tick();
      check("mt_over_val", new_val, 4'd0);
      up_btn = 1'b0;
      tick();
      q_mt = 4'd3;
      up_btn = 1'b1;
      tick();
      check("mt_inc_val", new_val, 4'd4);
      up_btn = 1'b0;
      tick();

      // Mode and up together: mode wins
      mode_btn = 1'b1;
      up_btn   = 1'b1;
      tick();
      check("both_sel", sel, 2'd3);
      check("both_strb", strb, 4'b0000);
      mode_btn = 1'b0;
      up_btn   = 1'b0;
      tick();

      // Auto-repeat in SET_MO
      q_mo = 4'd4;
      up_btn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("rpt_strb", strb,
               (k == 0 || k == 8 || k == 12 || k == 16) ? 4'b0001 : 4'b0000);
         if (k == 0) check("rpt_val", new_val, 4'd5);
      end
      up_btn = 1'b0;
      tick();

      // Idle timeout in SET_MT: MO -> RUN -> HT -> HO, then enter MT
      mode_pulse();
      mode_pulse();
      mode_pulse();
      q_ht = 4'd1; q_ho = 4'd0;
      mode_btn = 1'b1;
      tick();
      check("to_entry_sel", sel, 2'd2);
      mode_btn = 1'b0;
      any_strb = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (strb != 4'b0000) any_strb = 1'b1;
         if (k == 63) begin
            check("to_pre_sel", sel, 2'd2);
            check("to_pre_run_en", run_en, 1'b0);
         end
      end
      check("to_run_en", run_en, 1'b1);
      check("to_sel", sel, 2'd0);
      check("to_no_strb", any_strb, 1'b0);

      // Reset mid-strobe in SET_HO
      mode_pulse();
      mode_pulse();
      q_ht = 4'd1; q_ho = 4'd2;
      up_btn = 1'b1;
      tick();
      check("pre_rst_strb", strb, 4'b0100);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_strb", strb, 4'b0000);
      check("async_rst_run_en", run_en, 1'b1);
      check("async_rst_sel", sel, 2'd0);
      check("async_rst_val", new_val, 4'd0);

      // Buttons held through reset release register as edges
      mode_btn = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      check("held_sel", sel, 2'd0);
      check("held_run_en", run_en, 1'b0);
      check("held_strb", strb, 4'b0000);
      mode_btn = 1'b0;
      up_btn   = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter REPEAT_DLY, default 50_000_000: cycles up_btn must be held before auto-repeat starts.
REQ-002 Parameter REPEAT_RATE, default 10_000_000: cycles between auto-repeat increments.
REQ-003 Parameter IDLE_TO, default 500_000_000: cycles without button activity before set mode is abandoned.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 mode_btn  input  1  debounced level; rising edge advances the set-mode state.
REQ-007 up_btn  input  1  debounced level; rising edge or auto-repeat increments the selected digit.
REQ-008 q_ht, q_ho, q_mt, q_mo  input  4 each  current hour-tens, hour-ones, minute-tens and minute-ones digit values.
REQ-009 set_ht, set_ho, set_mt, set_mo  output  1 each  registered one-cycle load strobes to the digit registers.
REQ-010 new_val  output  4  registered value to load, shared by all four strobes.
REQ-011 sel  output  2  selected digit: 0=HT, 1=HO, 2=MT, 3=MO; 0 in RUN.
REQ-012 run_en  output  1  high only in RUN; gates the time-base increment to the digit chain.

Function
REQ-013 States SHALL be RUN, SET_HT, SET_HO, SET_MT and SET_MO.
REQ-014 Button edges: a rising edge is a sample of 1 where the previous registered sample is 0; the previous-sample registers reset to 0.
REQ-015 Mode-edge transitions: RUN->SET_HT->SET_HO->SET_MT->SET_MO->RUN.
REQ-016 An up event in SET_x SHALL assert set_x and drive new_val = incremented q_x for exactly one cycle, beginning at the clock edge that detects the event.
REQ-017 Increment limits: HT wraps 2->0; HO wraps 9->0, or 3->0 when q_ht==2; MT wraps 5->0; MO wraps 9->0.
REQ-018 An input digit above its limit SHALL increment to 0.
REQ-019 Up events in RUN SHALL be ignored, with no strobe.
REQ-020 On a mode edge leaving SET_HT with q_ht==2 and q_ho>3, set_ho SHALL pulse with new_val=0 at the transition edge.
REQ-021 Mode edge and up event on the same cycle: the mode edge wins and the up event is discarded.
REQ-022 Auto-repeat: while up_btn is held in a SET state, repeat events SHALL occur REPEAT_DLY cycles after the rising edge, then every REPEAT_RATE cycles.
REQ-023 The repeat counter SHALL clear on up_btn low or on any state change.
REQ-024 Idle timeout: in any SET state, IDLE_TO consecutive cycles with no mode edge, no up edge and up_btn low SHALL force RUN with no strobe.
REQ-025 The idle counter SHALL clear on any activity or on entry to RUN.
REQ-026 At most one set_* strobe SHALL be high in any cycle.
REQ-027 When no strobe is high, new_val SHALL hold its last value.
REQ-028 sel and run_en SHALL be decoded from the state register only, with no combinational path from any input.
REQ-029 Repeat and idle counters SHALL saturate and never wrap, and SHALL be sized for their parameter values.

Reset
REQ-030 resetn low SHALL immediately force state RUN, sel=0, run_en=1, all set_* 0 and new_val 0.
REQ-031 resetn low SHALL also immediately clear both counters and both previous-sample registers.
REQ-032 Reset asserted mid-strobe SHALL terminate the strobe at once.
REQ-033 After resetn deasserts, a button already held high SHALL register as a rising edge on the first sampled cycle.

Verification (bench parameters: REPEAT_DLY=8, REPEAT_RATE=4, IDLE_TO=64)
REQ-034 Mode walk: five mode edges from RUN -> sel 0,1,2,3 in turn, then RUN with run_en=1; no set_* strobe, given q_ht=1 and q_ho=5.
REQ-035 Hour wrap: SET_HO, q_ht=2, q_ho=3, one up edge -> set_ho high for exactly 1 cycle with new_val=0.
REQ-036 Clamp: q_ht=2, q_ho=7, mode edge in SET_HT -> set_ho pulse with new_val=0 and sel=1 on the same edge.
REQ-037 Auto-repeat: SET_MO, q_mo=4, up_btn held 20 cycles -> set_mo pulses at cycles 0, 8, 12, 16 after the rising edge.
REQ-038 Timeout: SET_MT, idle 64 cycles -> RUN on cycle 64 with no strobe; mode edge and up edge on the same cycle in SET_MT -> SET_MO with no set_mt.
REQ-039 Reset mid-operation: resetn low during SET_HO with set_ho high -> set_ho=0, run_en=1 and sel=0 asynchronously, before the next clock edge.
